// File: rtl/row_packer_if.sv
// row_packer_if: pixel-stream input and packed-row output handshakes for row_packer
interface row_packer_if #(
    parameter int IMG_W = 416,
    parameter int PIX_W = 8,
    parameter int CNT_W = 9
);
    logic                   pix_valid;
    logic                   pix_ready;
    logic [PIX_W-1:0]       pix_r;
    logic [PIX_W-1:0]       pix_g;
    logic [PIX_W-1:0]       pix_b;
    logic                   row_valid;
    logic                   row_ready;
    logic [CNT_W-1:0]       row_count;
    logic [IMG_W*PIX_W-1:0] R_row;
    logic [IMG_W*PIX_W-1:0] G_row;
    logic [IMG_W*PIX_W-1:0] B_row;
    modport master (
        output pix_valid, pix_r, pix_g, pix_b, row_ready,
        input  pix_ready, row_valid, row_count, R_row, G_row, B_row
    );
    modport slave (
        input  pix_valid, pix_r, pix_g, pix_b, row_ready,
        output pix_ready, row_valid, row_count, R_row, G_row, B_row
    );
endinterface

// File: rtl/row_packer.sv
// row_packer: packs raster RGB pixels into row words and emits top-pad, image and bottom-pad row beats
module row_packer #(
    parameter int IMG_W = 416,
    parameter int IMG_H = 416,
    parameter int PIX_W = 8,
    parameter int CNT_W = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            frame_start,
    row_packer_if.slave     io,
    output logic            busy,
    output logic            frame_done
);
    localparam int XW = IMG_W > 1 ? $clog2(IMG_W) : 1;
    localparam int IW = $clog2(IMG_W * PIX_W);
    typedef enum logic [2:0] {IDLE, TOP, FILL, EMIT, BOTTOM} state_t;
    state_t                 state, state_nx;
    logic [XW-1:0]          pix_cnt;
    logic [CNT_W-1:0]       row_cnt;
    logic [IMG_W*PIX_W-1:0] r_q, g_q, b_q;
    logic [IW-1:0]          idx;
    logic                   pix_fire, row_fire, last_pix, last_row;
    assign pix_fire      = state == FILL && io.pix_valid;
    assign row_fire      = io.row_valid && io.row_ready;
    assign last_pix      = pix_cnt == XW'(IMG_W - 1);
    assign last_row      = row_cnt == CNT_W'(IMG_H);
    // pixel k lands in the k-th byte from the MSB end
    assign idx           = IW'((IMG_W - int'(pix_cnt)) * PIX_W - 1);
    assign io.pix_ready  = state == FILL;
    assign io.row_valid  = state == TOP || state == EMIT || state == BOTTOM;
    assign io.row_count  = row_cnt;
    assign io.R_row      = r_q;
    assign io.G_row      = g_q;
    assign io.B_row      = b_q;
    assign busy          = state != IDLE;
    assign frame_done    = state == BOTTOM && io.row_ready;
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = frame_start ? TOP : IDLE;
            TOP:     state_nx = row_fire ? FILL : TOP;
            FILL:    state_nx = pix_fire && last_pix ? EMIT : FILL;
            EMIT:    state_nx = row_fire ? (last_row ? BOTTOM : FILL) : EMIT;
            BOTTOM:  state_nx = row_fire ? IDLE : BOTTOM;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt <= '0;
            row_cnt <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            if (state == IDLE && frame_start) begin
                row_cnt <= '0;
                r_q     <= '0;
                g_q     <= '0;
                b_q     <= '0;
            end
            if (state == TOP && row_fire) begin
                row_cnt <= CNT_W'(1);
                pix_cnt <= '0;
            end
            if (pix_fire) begin
                r_q[idx -: PIX_W] <= io.pix_r;
                g_q[idx -: PIX_W] <= io.pix_g;
                b_q[idx -: PIX_W] <= io.pix_b;
                pix_cnt           <= last_pix ? '0 : pix_cnt + 1'b1;
            end
            if (state == EMIT && row_fire) begin
                row_cnt <= row_cnt + 1'b1;
                pix_cnt <= '0;
                if (last_row) begin
                    r_q <= '0;
                    g_q <= '0;
                    b_q <= '0;
                end
            end
            if (state == BOTTOM && row_fire)
                row_cnt <= '0;
        end
    end
endmodule
